pwm_voice: RTL and testbench

PWM_VOICE -- requirements
Module: pwm_voice

---
 rtl/pwm_voice_pkg.sv | 20 ++
 rtl/pwm_voice_if.sv | 43 ++++
 rtl/pwm_voice_phase_accumulator.sv | 39 +++
 rtl/pwm_voice.sv | 97 +++++++++
 tb/tb_pwm_voice.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_voice_pkg.sv
// -----------------------------------------------------------------------------
// pwm_voice_pkg -- shared definitions for the PWM voice block.
//   Width constants for the phase accumulator, level and PWM counter, the
//   reset-time PWM period top, and the duty thresholds used when
//   PWM_VOICE_DUTY_EN is defined.
// No ports.
// -----------------------------------------------------------------------------
package pwm_voice_pkg;

    localparam int ACC_W = 32;  // phase accumulator / phase increment
    localparam int LVL_W = 9;   // envelope / output level
    localparam int CNT_W = 8;   // PWM counter / period top

    localparam logic [CNT_W-1:0] DEF_TOP = 8'hFF;

    // Threshold T on acc[31:29]: wave = (acc[31:29] < T).
    // Index = duty code: 0 -> 12.5%, 1 -> 25%, 2 -> 50%, 3 -> 75%.
    localparam logic [3:0][2:0] DUTY_T = {3'd6, 3'd4, 3'd2, 3'd1};

endpackage

// File: rtl/pwm_voice_if.sv
// -----------------------------------------------------------------------------
// pwm_voice_if -- control/audio bundle between the note sequencer and the
// PWM voice.
//   i_top / i_top_valid : requested PWM counter top and its qualifier
//   i_phase_delta       : per-clock phase increment
//   i_envelope          : amplitude level
//   i_duty              : duty select (only with PWM_VOICE_DUTY_EN)
//   o_pwm               : registered PWM audio output
//   o_period_start      : strobe on the first cycle of each PWM period
//   o_level             : level in force for the current PWM period
// master = sequencer side, slave = pwm_voice side.
// -----------------------------------------------------------------------------
interface pwm_voice_if;
    import pwm_voice_pkg::*;

    logic [CNT_W-1:0] i_top;
    logic             i_top_valid;
    logic [ACC_W-1:0] i_phase_delta;
    logic [LVL_W-1:0] i_envelope;
`ifdef PWM_VOICE_DUTY_EN
    logic [1:0]       i_duty;
`endif
    logic             o_pwm;
    logic             o_period_start;
    logic [LVL_W-1:0] o_level;

    modport master (
        output i_top, i_top_valid, i_phase_delta, i_envelope,
`ifdef PWM_VOICE_DUTY_EN
        output i_duty,
`endif
        input  o_pwm, o_period_start, o_level
    );

    modport slave (
        input  i_top, i_top_valid, i_phase_delta, i_envelope,
`ifdef PWM_VOICE_DUTY_EN
        input  i_duty,
`endif
        output o_pwm, o_period_start, o_level
    );

endinterface

// File: rtl/pwm_voice_phase_accumulator.sv
// -----------------------------------------------------------------------------
// phase_accumulator -- 32-bit free-running phase accumulator plus waveform
// decode for the PWM voice.
//   i_clk, i_rst : clock, synchronous active-high reset (acc -> 0)
//   i_en         : accumulate enable
//   i_delta      : phase increment added every enabled cycle (wraps mod 2^32)
//   i_duty       : duty code (only with PWM_VOICE_DUTY_EN)
//   o_wave       : square wave; acc[31] by default, threshold on acc[31:29]
//                  when PWM_VOICE_DUTY_EN is defined
// -----------------------------------------------------------------------------
module phase_accumulator
    import pwm_voice_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_delta,
`ifdef PWM_VOICE_DUTY_EN
    input  logic [1:0]       i_duty,
`endif
    output logic             o_wave
);

    logic [ACC_W-1:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + i_delta;
    end

`ifdef PWM_VOICE_DUTY_EN
    assign o_wave = (r_acc[ACC_W-1 -: 3] < DUTY_T[i_duty]);
`else
    assign o_wave = r_acc[ACC_W-1];
`endif

endmodule

// File: rtl/pwm_voice.sv
// -----------------------------------------------------------------------------
// pwm_voice -- one PWM audio voice: phase accumulator square wave, amplitude
// latched once per PWM period, registered PWM comparator.
//   Parameter DEFAULT_TOP : PWM counter top used after reset (period = top+1)
//   i_clk, i_rst          : clock, synchronous active-high reset
//   io_bus                : pwm_voice_if.slave (top request, phase delta,
//                           envelope, PWM/level/period-start outputs)
// Optional feature macro: PWM_VOICE_DUTY_EN adds io_bus.i_duty, a selectable
// 12.5/25/50/75% duty for the square wave.
// All per-period parameters (top, delta, envelope, duty) are only taken on the
// boundary cycle (cnt == top_act), so a period never changes length once
// started; a top request arriving mid-period waits in the pending register.
// -----------------------------------------------------------------------------
module pwm_voice
    import pwm_voice_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEFAULT_TOP = DEF_TOP
) (
    input  logic       i_clk,
    input  logic       i_rst,
    pwm_voice_if.slave io_bus
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_top_act;
    logic [CNT_W-1:0] r_top_pend;
    logic [ACC_W-1:0] r_delta_act;
    logic [LVL_W-1:0] r_env_act;
    logic             r_wave_lat;   // wave sampled at the boundary
    logic             r_pwm;
    logic             r_ps;
`ifdef PWM_VOICE_DUTY_EN
    logic [1:0]       r_duty_act;
`endif

    logic             w_bnd;
    logic             w_wave;
    logic [LVL_W-1:0] w_level;

    assign w_bnd   = (r_cnt == r_top_act);
    // Level for the current period: envelope gated by the wave state, both
    // captured together on the boundary and held until the next one.
    assign w_level = r_wave_lat ? r_env_act : '0;

    phase_accumulator u_phase (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (1'b1),
        .i_delta (r_delta_act),
`ifdef PWM_VOICE_DUTY_EN
        .i_duty  (r_duty_act),
`endif
        .o_wave  (w_wave)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_top_act   <= DEFAULT_TOP;
            r_top_pend  <= DEFAULT_TOP;
            r_delta_act <= '0;
            r_env_act   <= '0;
            r_wave_lat  <= 1'b0;
            r_pwm       <= 1'b0;
            r_ps        <= 1'b0;
`ifdef PWM_VOICE_DUTY_EN
            r_duty_act  <= 2'd2;
`endif
        end else begin
            if (io_bus.i_top_valid)
                r_top_pend <= io_bus.i_top;

            // Compare against the level of the period cnt belongs to.
            r_pwm <= ({1'b0, r_cnt} < w_level);
            r_ps  <= w_bnd;

            if (w_bnd) begin
                r_cnt       <= '0;
                // A request on the boundary itself bypasses the pending reg.
                r_top_act   <= io_bus.i_top_valid ? io_bus.i_top : r_top_pend;
                r_delta_act <= io_bus.i_phase_delta;
                r_env_act   <= io_bus.i_envelope;
                r_wave_lat  <= w_wave;
`ifdef PWM_VOICE_DUTY_EN
                r_duty_act  <= io_bus.i_duty;
`endif
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign io_bus.o_pwm          = r_pwm;
    assign io_bus.o_period_start = r_ps;
    assign io_bus.o_level        = w_level;

endmodule

// File: tb/tb_pwm_voice.sv
// -----------------------------------------------------------------------------
// tb_pwm_voice -- self-checking bench for pwm_voice (default build).
// A cycle reference model pushes the expected outputs for every clock into a
// scoreboard queue as inputs are applied; after the edge the entry is popped
// and compared. Directed scenarios add period-length, level and accumulator
// checks on top.
// -----------------------------------------------------------------------------
module tb_pwm_voice;
    import pwm_voice_pkg::*;

    localparam logic [7:0] DEF = 8'hFF;

    logic i_clk = 1'b0;
    logic i_rst;

    pwm_voice_if vif ();

    pwm_voice #(.DEFAULT_TOP(DEF)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .io_bus (vif.slave)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       pwm;
        logic       ps;
        logic [8:0] lvl;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    // reference model state
    logic [7:0]  m_cnt, m_top, m_pend;
    logic [31:0] m_acc, m_delta;
    logic [8:0]  m_lvl;
    logic        m_pwm, m_ps;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    // Advance the model across one edge using the inputs now on the bus.
    task automatic model_push();
        exp_t e;
        logic bnd, wave;
        if (i_rst) begin
            m_cnt = 8'd0;  m_acc = 32'd0; m_top = DEF; m_pend = DEF;
            m_delta = 32'd0; m_lvl = 9'd0; m_pwm = 1'b0; m_ps = 1'b0;
        end else begin
            bnd   = (m_cnt == m_top);
            wave  = m_acc[31];
            m_pwm = ({1'b0, m_cnt} < m_lvl);
            m_ps  = bnd;
            m_acc = m_acc + m_delta;
            if (bnd) begin
                m_lvl   = wave ? vif.i_envelope : 9'd0;
                m_top   = vif.i_top_valid ? vif.i_top : m_pend;
                m_delta = vif.i_phase_delta;
                m_cnt   = 8'd0;
            end else begin
                m_cnt = m_cnt + 8'd1;
            end
            if (vif.i_top_valid) m_pend = vif.i_top;
        end
        e.pwm = m_pwm; e.ps = m_ps; e.lvl = m_lvl;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_push();
        @(posedge i_clk);
        @(negedge i_clk);
        cyc_n++;
        e = sb_q.pop_front();
        chk("sb_pwm", 32'(vif.o_pwm), 32'(e.pwm));
        chk("sb_ps",  32'(vif.o_period_start), 32'(e.ps));
        chk("sb_lvl", 32'(vif.o_level), 32'(e.lvl));
    endtask

    task automatic wait_ps(output int at);
        for (int k = 0; k < 600; k++) begin
            cyc();
            if (vif.o_period_start) break;
        end
        chk("ps_seen", 32'(vif.o_period_start), 32'd1);
        at = cyc_n;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p1, p2, p3, p4, r0, hi;
        logic [31:0] a_exp;

        vif.i_top = 8'd0; vif.i_top_valid = 1'b0;
        vif.i_phase_delta = 32'd0; vif.i_envelope = 9'd0;
`ifdef PWM_VOICE_DUTY_EN
        vif.i_duty = 2'd2;
`endif
        // ---- reset state
        do_reset();
        chk("rst_pwm", 32'(vif.o_pwm), 32'd0);
        chk("rst_ps",  32'(vif.o_period_start), 32'd0);
        chk("rst_lvl", 32'(vif.o_level), 32'd0);
        chk("rst_cnt", 32'(dut.r_cnt), 32'd0);
        r0 = cyc_n;

        // ---- top=3, delta=0, env=20: silent, period 4
        vif.i_top = 8'd3; vif.i_top_valid = 1'b1; vif.i_envelope = 9'd20;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p);
        chk("rst_len", 32'(p - r0), 32'd256);
        for (int k = 0; k < 3; k++) begin
            wait_ps(p1);
            chk("A_len", 32'(p1 - p), 32'd4);
            chk("A_lvl", 32'(vif.o_level), 32'd0);
            p = p1;
        end

        // ---- delta=2^29, env=2: level alternates 0/2 per period
        vif.i_phase_delta = 32'h2000_0000; vif.i_envelope = 9'd2;
        wait_ps(p);
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc();
                hi += int'(vif.o_pwm);
            end
            chk("B_ps",  32'(vif.o_period_start), 32'd1);
            chk("B_lvl", 32'(vif.o_level), (k % 2 == 1) ? 32'd2 : 32'd0);
        end
        chk("B_hi", 32'(hi), 32'd4);

        // ---- top=7, then i_top=3 pulsed mid-period at cnt=2
        vif.i_top = 8'd7; vif.i_top_valid = 1'b1;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p);
        cyc(); cyc();
        vif.i_top = 8'd3; vif.i_top_valid = 1'b1;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p1);
        chk("C_len8", 32'(p1 - p), 32'd8);
        wait_ps(p2);
        chk("C_len4", 32'(p2 - p1), 32'd4);

        // ---- top=7, then i_top=3 pulsed on the boundary (cnt=7)
        vif.i_top = 8'd7; vif.i_top_valid = 1'b1;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p3);
        chk("C_len4b", 32'(p3 - p2), 32'd4);
        for (int k = 0; k < 7; k++) cyc();
        vif.i_top = 8'd3; vif.i_top_valid = 1'b1;
        cyc();
        vif.i_top_valid = 1'b0;
        chk("C_ps7", 32'(vif.o_period_start), 32'd1);
        chk("C_len8b", 32'(cyc_n - p3), 32'd8);
        wait_ps(p4);
        chk("C_len4c", 32'(p4 - p3), 32'd12);

        // ---- top=0: one-clock periods, strobe stays high
        vif.i_top = 8'd0; vif.i_top_valid = 1'b1;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("Z_ps", 32'(vif.o_period_start), 32'd1);
        end

        // ---- delta=FFFF_FFFF from acc=0: wraps and counts down
        do_reset();
        vif.i_phase_delta = 32'hFFFF_FFFF;
        wait_ps(p);
        chk("E_acc0", dut.u_phase.r_acc, 32'd0);
        a_exp = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("E_acc", dut.u_phase.r_acc, a_exp);
            a_exp = a_exp - 32'd1;
        end

        // ---- top=255, env=1FF, wave high: o_pwm high for all 256 cycles
        do_reset();
        r0 = cyc_n;
        vif.i_phase_delta = 32'h0100_0000; vif.i_envelope = 9'h1FF;
        wait_ps(p);
        chk("D_len0", 32'(p - r0), 32'd256);
        wait_ps(p1);
        chk("D_len", 32'(p1 - p), 32'd256);
        chk("D_lvl", 32'(vif.o_level), 32'h1FF);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            cyc();
            hi += int'(vif.o_pwm);
        end
        chk("D_hi", 32'(hi), 32'd256);

        // ---- reset mid-period at cnt=5 with top=15, env=30
        vif.i_top = 8'd15; vif.i_top_valid = 1'b1; vif.i_envelope = 9'd30;
        cyc();
        vif.i_top_valid = 1'b0;
        wait_ps(p);
        for (int k = 0; k < 5; k++) cyc();
        chk("R_cnt_pre", 32'(dut.r_cnt), 32'd5);
        chk("R_lvl_pre", 32'(vif.o_level), 32'd30);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        chk("R_pwm", 32'(vif.o_pwm), 32'd0);
        chk("R_ps",  32'(vif.o_period_start), 32'd0);
        chk("R_lvl", 32'(vif.o_level), 32'd0);
        chk("R_cnt", 32'(dut.r_cnt), 32'd0);
        chk("R_acc", dut.u_phase.r_acc, 32'd0);
        r0 = cyc_n;
        wait_ps(p);
        chk("R_len", 32'(p - r0), 32'd256);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
